axi_ad9364_dac_sched: RTL and testbench

//  Transmit-side sample scheduler for the AD9364 digital interface.
//  - Buffers upstream I/Q samples in a small FIFO.
//  - Drives dac_valid/dac_data_* into axi_ad9364_dig_if at the slot rate set by the channel mode.
//  - Handles start/stop sequencing, prefill and underflow.
//  - Sits between the DMA/DDS source and the dig_if TX port, all in the interface clk domain.

---
 rtl/axi_ad9364_dac_sched_if.sv | 16 +
 rtl/axi_ad9364_dac_sched.sv | 264 ++++++++++++++++++++++++++
 tb/tb_axi_ad9364_dac_sched.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ad9364_dac_sched_if.sv
// ---------------------------------------------------------------------------
// axi_ad9364_dac_sched_if
//   Upstream sample stream between the DMA/DDS source and the TX scheduler.
//   s_valid : source has a sample on s_data
//   s_ready : scheduler can accept; a transfer happens when s_valid & s_ready
//   s_data  : {q2, i2, q1, i1}, 12 bits each
//   master modport = sample source, slave modport = scheduler.
// ---------------------------------------------------------------------------
interface axi_ad9364_dac_sched_if;
    logic        s_valid;
    logic        s_ready;
    logic [47:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/axi_ad9364_dac_sched.sv
// ---------------------------------------------------------------------------
// axi_ad9364_dac_sched
//   Transmit-side sample scheduler for the AD9364 digital interface. Buffers
//   upstream I/Q samples in a small FIFO and presents one sample per slot to
//   axi_ad9364_dig_if (slot period 2 clocks in 1T, 4 clocks in 2T), with
//   start/prefill/stop sequencing and sticky underflow reporting.
//
//   Ports
//     clk, rstn        interface clock, asynchronous active-low reset
//     enable           1 = start/keep streaming, 0 = stop
//     r1_mode          1 = 1T, 0 = 2T; latched on IDLE->FILL only
//     s_if (slave)     upstream sample stream {q2,i2,q1,i1}
//     dac_valid        one-cycle strobe per sample slot
//     dac_data_*       sample lanes (i2/q2 forced 0 in 1T)
//     dac_r1_mode      latched mode presented to dig_if
//     underflow        sticky, a slot occurred with the FIFO empty
//     underflow_clr    clears underflow (a simultaneous set wins)
//     state            0 IDLE, 1 FILL, 2 RUN, 3 STOP
//     pattern_sel      only with AD9364_DAC_SCHED_PATTERN_EN defined
//
//   Build option: define AD9364_DAC_SCHED_PATTERN_EN to add pattern_sel, which
//   replaces FIFO data with a fixed two-entry test pattern while in RUN.
// ---------------------------------------------------------------------------
module axi_ad9364_dac_sched #(
    parameter int unsigned FIFO_DEPTH = 4,   // power of 2, 2..16
    parameter int unsigned FILL_LEVEL = 2    // 1..FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  r1_mode,
    axi_ad9364_dac_sched_if.slave s_if,
`ifdef AD9364_DAC_SCHED_PATTERN_EN
    input  logic                  pattern_sel,
`endif
    output logic                  dac_valid,
    output logic [11:0]           dac_data_i1,
    output logic [11:0]           dac_data_q1,
    output logic [11:0]           dac_data_i2,
    output logic [11:0]           dac_data_q2,
    output logic                  dac_r1_mode,
    output logic                  underflow,
    input  logic                  underflow_clr,
    output logic [1:0]            state
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] FILL_C  = CW'(FILL_LEVEL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      slot_q, slot_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [47:0]     mem_q [FIFO_DEPTH];
    logic [47:0]     mem_d [FIFO_DEPTH];
    logic            dac_valid_q, dac_valid_d;
    logic [11:0]     i1_q, i1_d, q1_q, q1_d, i2_q, i2_d, q2_q, q2_d;
    logic            dac_r1_mode_q, dac_r1_mode_d;
    logic            underflow_q, underflow_d;
`ifdef AD9364_DAC_SCHED_PATTERN_EN
    logic            pat_q, pat_d;
`endif

    logic            fifo_full;
    logic            fifo_empty;
    logic            ready;
    logic            push;
    logic            pop;
    logic            last_slot;
    logic [1:0]      slot_next;
    logic            slot_fire;
    logic            pat_slot;
    logic [47:0]     head;

    always_comb begin
        fifo_full  = (count_q == DEPTH_C);
        fifo_empty = (count_q == '0);
        ready      = ((state_q == ST_FILL) || (state_q == ST_RUN)) && !fifo_full;
        push       = s_if.s_valid && ready;
        head       = mem_q[rd_ptr_q];

        // Slot period is 2 clocks in 1T, 4 clocks in 2T.
        last_slot  = dac_r1_mode_q ? (slot_q == 2'd1) : (slot_q == 2'd3);
        slot_next  = last_slot ? 2'd0 : slot_q + 2'd1;

        state_d       = state_q;
        slot_d        = slot_q;
        dac_r1_mode_d = dac_r1_mode_q;

        case (state_q)
            ST_IDLE: begin
                slot_d = '0;
                if (enable) begin
                    state_d       = ST_FILL;
                    dac_r1_mode_d = r1_mode;
                end
            end
            ST_FILL: begin
                slot_d = '0;
                // Prefill counts the sample being accepted this cycle, so RUN
                // starts right after the FILL_LEVEL-th transfer.
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if ((count_q + CW'(push)) >= FILL_C) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                slot_d = slot_next;
                // Stopping on the last count of a period has nothing left to
                // run out, so go straight back to IDLE.
                if (!enable) begin
                    state_d = last_slot ? ST_IDLE : ST_STOP;
                end
            end
            ST_STOP: begin
                slot_d = slot_next;
                if (last_slot) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = '0;
            end
        endcase

        // Outputs are registered: a slot is launched on the edge where the
        // counter enters 0 in RUN, so dac_valid is seen while counter == 0,
        // including the first RUN cycle.
        slot_fire   = (state_d == ST_RUN) && (slot_d == 2'd0);
        dac_valid_d = slot_fire;

`ifdef AD9364_DAC_SCHED_PATTERN_EN
        pat_slot = slot_fire && pattern_sel;
        pat_d    = (state_q == ST_RUN) ? pat_q : 1'b0;
`else
        pat_slot = 1'b0;
`endif

        pop = slot_fire && !pat_slot && !fifo_empty;

        i1_d = i1_q;
        q1_d = q1_q;
        i2_d = i2_q;
        q2_d = q2_q;

        underflow_d = underflow_clr ? 1'b0 : underflow_q;

        if (slot_fire && !pat_slot) begin
            if (fifo_empty) begin
                i1_d        = '0;
                q1_d        = '0;
                i2_d        = '0;
                q2_d        = '0;
                underflow_d = 1'b1;
            end else begin
                i1_d = head[11:0];
                q1_d = head[23:12];
                i2_d = dac_r1_mode_q ? 12'd0 : head[35:24];
                q2_d = dac_r1_mode_q ? 12'd0 : head[47:36];
            end
        end

`ifdef AD9364_DAC_SCHED_PATTERN_EN
        if (pat_slot) begin
            // pat_d holds the current phase here (reset to 0 outside RUN).
            i1_d  = pat_d ? 12'o4402 : 12'o2064;
            q1_d  = pat_d ? 12'o1337 : 12'o1753;
            i2_d  = dac_r1_mode_q ? 12'd0 : i1_d;
            q2_d  = dac_r1_mode_q ? 12'd0 : q1_d;
            pat_d = ~pat_d;
        end
`endif

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = s_if.s_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Entering or sitting in IDLE flushes the FIFO and clears the lanes.
        if (state_d == ST_IDLE) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            i1_d     = '0;
            q1_d     = '0;
            i2_d     = '0;
            q2_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            slot_q        <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_q         <= '{default: '0};
            dac_valid_q   <= 1'b0;
            i1_q          <= '0;
            q1_q          <= '0;
            i2_q          <= '0;
            q2_q          <= '0;
            dac_r1_mode_q <= 1'b0;
            underflow_q   <= 1'b0;
`ifdef AD9364_DAC_SCHED_PATTERN_EN
            pat_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_q         <= mem_d;
            dac_valid_q   <= dac_valid_d;
            i1_q          <= i1_d;
            q1_q          <= q1_d;
            i2_q          <= i2_d;
            q2_q          <= q2_d;
            dac_r1_mode_q <= dac_r1_mode_d;
            underflow_q   <= underflow_d;
`ifdef AD9364_DAC_SCHED_PATTERN_EN
            pat_q         <= pat_d;
`endif
        end
    end

    assign s_if.s_ready = ready;
    assign dac_valid    = dac_valid_q;
    assign dac_data_i1  = i1_q;
    assign dac_data_q1  = q1_q;
    assign dac_data_i2  = i2_q;
    assign dac_data_q2  = q2_q;
    assign dac_r1_mode  = dac_r1_mode_q;
    assign underflow    = underflow_q;
    assign state        = state_q;

endmodule

// File: tb/tb_axi_ad9364_dac_sched.sv
// ---------------------------------------------------------------------------
// tb_axi_ad9364_dac_sched
//   Directed bench for axi_ad9364_dac_sched (FIFO_DEPTH=4, FILL_LEVEL=2).
//   A cycle table covers a 1T stream through drain, underflow and stop;
//   hand sequences cover 2T ordering/spacing, stop timing, flush on restart,
//   asynchronous reset mid-stream and (when built with the pattern option)
//   the test pattern.
//   Sample n is {q2,i2,q1,i1} = {0x400+n, 0x300+n, 0x200+n, 0x100+n}.
// ---------------------------------------------------------------------------
module tb_axi_ad9364_dac_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        r1_mode;
    logic        underflow_clr;
    logic        dac_valid;
    logic [11:0] dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2;
    logic        dac_r1_mode;
    logic        underflow;
    logic [1:0]  state;
`ifdef AD9364_DAC_SCHED_PATTERN_EN
    logic        pattern_sel;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    axi_ad9364_dac_sched_if sif ();

    axi_ad9364_dac_sched #(
        .FIFO_DEPTH (4),
        .FILL_LEVEL (2)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .r1_mode       (r1_mode),
        .s_if          (sif),
`ifdef AD9364_DAC_SCHED_PATTERN_EN
        .pattern_sel   (pattern_sel),
`endif
        .dac_valid     (dac_valid),
        .dac_data_i1   (dac_data_i1),
        .dac_data_q1   (dac_data_q1),
        .dac_data_i2   (dac_data_i2),
        .dac_data_q2   (dac_data_q2),
        .dac_r1_mode   (dac_r1_mode),
        .underflow     (underflow),
        .underflow_clr (underflow_clr),
        .state         (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [1:0]  st;
        logic        rdy;
        logic        val;
        logic [11:0] i1;
        logic [11:0] q1;
        logic [11:0] i2;
        logic [11:0] q2;
        logic        r1;
        logic        uf;
    } obs_t;

    typedef struct packed {
        logic        en;
        logic        r1;
        logic        sv;
        logic [47:0] sd;
        logic        clr;
        obs_t        exp;
    } vec_t;

    localparam int NV = 26;
    vec_t vec [NV];

    function automatic logic [47:0] mk(input int n);
        return {12'(n + 'h400), 12'(n + 'h300), 12'(n + 'h200), 12'(n + 'h100)};
    endfunction

    // Expected observation with 1T lanes (i2/q2 always zero); didx < 0 = zero lanes.
    function automatic obs_t ob(input logic [1:0] st, input logic rdy, input logic val,
                                input int didx, input logic r1, input logic uf);
        obs_t o;
        o.st  = st;
        o.rdy = rdy;
        o.val = val;
        o.i1  = (didx < 0) ? 12'd0 : 12'(didx + 'h100);
        o.q1  = (didx < 0) ? 12'd0 : 12'(didx + 'h200);
        o.i2  = 12'd0;
        o.q2  = 12'd0;
        o.r1  = r1;
        o.uf  = uf;
        return o;
    endfunction

    function automatic vec_t vv(input logic en, input logic r1, input logic sv,
                                input int sidx, input logic clr, input obs_t e);
        vec_t v;
        v.en  = en;
        v.r1  = r1;
        v.sv  = sv;
        v.sd  = (sidx < 0) ? 48'd0 : mk(sidx);
        v.clr = clr;
        v.exp = e;
        return v;
    endfunction

    function automatic obs_t sample_obs();
        obs_t o;
        o.st  = state;
        o.rdy = sif.s_ready;
        o.val = dac_valid;
        o.i1  = dac_data_i1;
        o.q1  = dac_data_q1;
        o.i2  = dac_data_i2;
        o.q2  = dac_data_q2;
        o.r1  = dac_r1_mode;
        o.uf  = underflow;
        return o;
    endfunction

    task automatic chk_obs(input string nm, input obs_t a, input obs_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got st=%0d rdy=%b val=%b i1=%h q1=%h i2=%h q2=%h r1=%b uf=%b, expected st=%0d rdy=%b val=%b i1=%h q1=%h i2=%h q2=%h r1=%b uf=%b",
                     nm, a.st, a.rdy, a.val, a.i1, a.q1, a.i2, a.q2, a.r1, a.uf,
                     e.st, e.rdy, e.val, e.i1, e.q1, e.i2, e.q2, e.r1, e.uf);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, a, e);
        end
    endtask

    task automatic wait_valid(input int unsigned maxc, input string nm, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < maxc; i++) begin
            @(negedge clk);
            #1;
            if (dac_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no dac_valid within %0d cycles", nm, maxc);
        end
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rstn          = 1'b0;
        enable        = 1'b0;
        r1_mode       = 1'b0;
        underflow_clr = 1'b0;
        sif.s_valid   = 1'b0;
        sif.s_data    = '0;
`ifdef AD9364_DAC_SCHED_PATTERN_EN
        pattern_sel   = 1'b0;
`endif
        @(negedge clk);
        #1;
        chk_obs(nm, sample_obs(), ob(2'd0, 1'b0, 1'b0, -1, 1'b0, 1'b0));
        rstn = 1'b1;
    endtask

    logic [47:0] exp_q [$];
    int          seq;
    int          last_v;
    int          nval;
    int unsigned max_occ;
    bit          ok;

    initial begin
        // 1T stream: prefill, steady state with a full FIFO, drain, underflow
        // with clear/set collision, then stop. r1_mode flips to 0 mid-RUN.
        //            en  r1  sv  sidx clr     st    rdy val didx r1 uf
        vec[0]  = vv(1, 1, 1,  0, 0, ob(2'd0, 0, 0, -1, 0, 0));
        vec[1]  = vv(1, 1, 1,  0, 0, ob(2'd1, 1, 0, -1, 1, 0));
        vec[2]  = vv(1, 1, 1,  1, 0, ob(2'd1, 1, 0, -1, 1, 0));
        vec[3]  = vv(1, 0, 1,  2, 0, ob(2'd2, 1, 1,  0, 1, 0));
        vec[4]  = vv(1, 0, 1,  3, 0, ob(2'd2, 1, 0,  0, 1, 0));
        vec[5]  = vv(1, 0, 1,  4, 0, ob(2'd2, 1, 1,  1, 1, 0));
        vec[6]  = vv(1, 0, 1,  5, 0, ob(2'd2, 1, 0,  1, 1, 0));
        vec[7]  = vv(1, 0, 1,  6, 0, ob(2'd2, 1, 1,  2, 1, 0));
        vec[8]  = vv(1, 0, 1,  7, 0, ob(2'd2, 0, 0,  2, 1, 0));
        vec[9]  = vv(1, 0, 1,  7, 0, ob(2'd2, 1, 1,  3, 1, 0));
        vec[10] = vv(1, 0, 1,  8, 0, ob(2'd2, 0, 0,  3, 1, 0));
        vec[11] = vv(1, 0, 0,  8, 0, ob(2'd2, 1, 1,  4, 1, 0));
        vec[12] = vv(1, 0, 0,  8, 0, ob(2'd2, 1, 0,  4, 1, 0));
        vec[13] = vv(1, 0, 0,  8, 0, ob(2'd2, 1, 1,  5, 1, 0));
        vec[14] = vv(1, 0, 0,  8, 0, ob(2'd2, 1, 0,  5, 1, 0));
        vec[15] = vv(1, 0, 0,  8, 0, ob(2'd2, 1, 1,  6, 1, 0));
        vec[16] = vv(1, 0, 0,  8, 0, ob(2'd2, 1, 0,  6, 1, 0));
        vec[17] = vv(1, 0, 0,  8, 0, ob(2'd2, 1, 1,  7, 1, 0));
        vec[18] = vv(1, 0, 0,  8, 0, ob(2'd2, 1, 0,  7, 1, 0));
        vec[19] = vv(1, 0, 0,  8, 0, ob(2'd2, 1, 1, -1, 1, 1));
        vec[20] = vv(1, 0, 0,  8, 1, ob(2'd2, 1, 0, -1, 1, 1));
        vec[21] = vv(1, 0, 0,  8, 1, ob(2'd2, 1, 1, -1, 1, 1));
        vec[22] = vv(1, 0, 0,  8, 0, ob(2'd2, 1, 0, -1, 1, 0));
        vec[23] = vv(0, 0, 0,  8, 0, ob(2'd2, 1, 1, -1, 1, 1));
        vec[24] = vv(0, 0, 0,  8, 0, ob(2'd3, 0, 0, -1, 1, 1));
        vec[25] = vv(0, 0, 0,  8, 0, ob(2'd0, 0, 0, -1, 1, 1));

        rstn = 1'b0;
        do_reset("reset_initial");

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            enable        = vec[k].en;
            r1_mode       = vec[k].r1;
            sif.s_valid   = vec[k].sv;
            sif.s_data    = vec[k].sd;
            underflow_clr = vec[k].clr;
            #1;
            chk_obs($sformatf("t1_vec%0d", k), sample_obs(), vec[k].exp);
        end

        // 2T stream with a continuously valid source.
        do_reset("reset_before_2t");
        seq     = 100;
        last_v  = -1;
        nval    = 0;
        max_occ = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            enable      = 1'b1;
            r1_mode     = 1'b0;
            sif.s_valid = 1'b1;
            sif.s_data  = mk(seq);
            #1;
            if (dac_valid) begin
                if (exp_q.size() == 0) begin
                    chk("t2_data_unexpected", {dac_data_q2, dac_data_i2, dac_data_q1, dac_data_i1}, 64'hDEAD);
                end else begin
                    chk($sformatf("t2_data_slot%0d", nval),
                        {dac_data_q2, dac_data_i2, dac_data_q1, dac_data_i1}, exp_q.pop_front());
                end
                if (last_v >= 0) chk($sformatf("t2_gap_slot%0d", nval), cyc - last_v, 4);
                last_v = cyc;
                nval++;
            end
            if (sif.s_valid && sif.s_ready) begin
                exp_q.push_back(mk(seq));
                seq++;
            end
            if (exp_q.size() > max_occ) max_occ = exp_q.size();
        end
        chk("t2_max_occupancy", max_occ, 4);
        chk("t2_slot_count", nval, 15);
        chk("t2_no_underflow", underflow, 1'b0);

        // Stop on a counter-0 cycle in 2T: three quiet STOP cycles, then IDLE.
        wait_valid(8, "t5_wait_slot", ok);
        enable = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("t5_stop_cycle%0d", i), {state, dac_valid, sif.s_ready}, {2'd3, 1'b0, 1'b0});
        end
        @(negedge clk);
        #1;
        chk("t5_idle_entry", {state, dac_valid, sif.s_ready, dac_data_q2, dac_data_i2, dac_data_q1, dac_data_i1},
            {2'd0, 1'b0, 1'b0, 48'd0});

        // Restart: the first slot must carry the first new sample (FIFO flushed).
        seq = 300;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            enable      = 1'b1;
            r1_mode     = 1'b0;
            sif.s_valid = 1'b1;
            sif.s_data  = mk(seq);
            #1;
            if (dac_valid) break;
            if (sif.s_valid && sif.s_ready) seq++;
        end
        chk("t5_restart_first_sample",
            {dac_valid, dac_data_q2, dac_data_i2, dac_data_q1, dac_data_i1}, {1'b1, mk(300)});

        // Asynchronous reset while streaming.
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_obs("t1_reset_async", sample_obs(), ob(2'd0, 1'b0, 1'b0, -1, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        chk_obs("t1_reset_next_cycle", sample_obs(), ob(2'd0, 1'b0, 1'b0, -1, 1'b0, 1'b0));
        rstn = 1'b1;

`ifdef AD9364_DAC_SCHED_PATTERN_EN
        // Pattern in 1T: two samples prefilled, pattern alternates, FIFO untouched.
        do_reset("reset_before_pattern");
        pattern_sel = 1'b1;
        seq = 200;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            enable      = 1'b1;
            r1_mode     = 1'b1;
            sif.s_valid = (seq < 202);
            sif.s_data  = mk(seq);
            #1;
            if (sif.s_valid && sif.s_ready) seq++;
        end
        sif.s_valid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            wait_valid(4, "t6_wait_slot", ok);
            chk($sformatf("t6_pattern%0d", p), {dac_data_q2, dac_data_i2, dac_data_q1, dac_data_i1},
                (p % 2 == 0) ? {24'd0, 12'h3EB, 12'h434} : {24'd0, 12'h2DF, 12'h902});
        end
        pattern_sel = 1'b0;
        wait_valid(4, "t6_wait_fifo_slot", ok);
        chk("t6_fifo_untouched", {underflow, dac_data_q1, dac_data_i1}, {1'b0, 12'h2C8, 12'h1C8});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
